serial_tx_arbiter: RTL
======================

Name: serial_tx_arbiter

Overview:
- Shares one serial transmitter (16-bit word, start/stop framing, Busy/send handshake) between NUM_REQ requesters.
- Picks requesters round-robin, latches the granted word, pulses send, then tracks the transmitter's Busy until the frame completes.
- Sits between CPU/IO-side producers and the serial transmitter in the serial controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, word width; matches transmitter DataIn.
- TIMEOUT, 64, cycles allowed for TxBusy to rise after send (optional feature only).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  NUM_REQ  per-requester word-pending flag; held until ReqAck.
- ReqData  in  NUM_REQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W].
- ReqAck  out  NUM_REQ  one-hot, one-cycle pulse when requester i's word is accepted.
- TxData  out  DATA_W  word to transmitter DataIn; registered.
- TxSend  out  1  one-cycle send pulse to transmitter.
- TxBusy  in  1  transmitter Busy.
- GrantId  out  clog2(NUM_REQ)  index of current/last granted requester.
- Idle  out  1  high in IDLE state.
- TxError  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: state IDLE; ReqAck=0; TxSend=0; TxData=0; GrantId=NUM_REQ-1; Idle=1; TxError=0; round-robin pointer = NUM_REQ-1, so requester 0 wins first. Reset mid-frame aborts tracking immediately. The transmitter finishes its frame independently. After reset the block waits in IDLE until TxBusy=0 before granting again.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If TxBusy=0 and any ReqValid, pick the first set bit searching from (pointer+1) mod NUM_REQ upward with wrap.
  - Latch its word into TxData; set GrantId and pointer to the winner; go to ISSUE.
  - If TxBusy=1, no grant.
- ISSUE: TxSend=1 and ReqAck[GrantId]=1 for exactly this cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for TxBusy=1, then go to WAIT_DONE. The transmitter raises Busy the cycle after sampling send.
- WAIT_DONE: wait for TxBusy=0, then go to IDLE.
- Latency:
  - Request to send pulse: 1 cycle (ReqValid seen in IDLE, TxSend on the next cycle).
  - Frame completion (TxBusy falls) to next grant decision: 1 cycle. WAIT_DONE→IDLE costs 1 cycle; the IDLE grant then occurs that cycle.
- TxData is stable from ISSUE through WAIT_DONE. It changes only on a grant.
- Requester rules:
  - A requester dropping ReqValid before ack is legal; it is simply not considered.
  - ReqData changes while not acked are legal; the value latched is the one present on the grant cycle.
  - A requester re-asserting immediately after ack waits for all other pending requesters (fairness).
- Simultaneous requests: all NUM_REQ valid continuously → grants cycle 0,1,2,3,0,...
- Single requester: it is granted back-to-back with no starvation penalty.

Optional Feature:
- Macro SERIAL_TX_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT_BUSY.
  - If TxBusy has not risen after TIMEOUT cycles, set TxError (sticky until Reset) and return to IDLE. The word is considered consumed; no resend.
  - Counter clears on entry to WAIT_BUSY.
- Disabled: no counter; WAIT_BUSY waits indefinitely; TxError tied 0.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding constants for IDLE/ISSUE/WAIT_BUSY/WAIT_DONE;
  - default DATA_W=16;
  - default TIMEOUT.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: winner index and found flag. Reusable by other shared-resource arbiters.

Test Plan:
- Reset then ReqValid=4'b0001, ReqData[0]=16'hA5C3 → TxSend and ReqAck=0001 one cycle later; TxData=16'hA5C3 held until TxBusy falls.
- ReqValid=4'b1111 held with a transmitter model → grant order 0,1,2,3,0; exactly one ReqAck per frame; no TxSend while TxBusy=1.
- ReqValid=4'b0100 asserted while TxBusy=1 (frame in progress) → no grant until cycle after TxBusy=0; then GrantId=2.
- Reset asserted in WAIT_DONE → Idle=1, ReqAck=0, GrantId=3 next cycle; no TxSend until TxBusy=0.
- Requester 1 drops ReqValid while requester 0's frame sends, requester 3 valid → next grant is 3, ReqAck[1] never pulses.
- With SERIAL_TX_ARB_TIMEOUT_EN, TxBusy tied 0 after send → TxError=1 after 64 WAIT_BUSY cycles, return to IDLE, next request still served; without macro → remains in WAIT_BUSY.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and defaults for the serial controller
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int unsigned SERIAL_DATA_W     = 16;
   localparam int unsigned SERIAL_TX_TIMEOUT = 64;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// rtl/serial_tx_arbiter_rr_pick.sv - combinational round-robin picker (rr_pick)
// Returns the first set request after i_ptr, wrapping; i_ptr itself is checked last.
module rr_pick
   import serial_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_idx   = i_ptr;
      o_found = 1'b0;
      w_cand  = i_ptr;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % int'(NUM_REQ));
         if (!o_found && i_req[w_cand]) begin
            o_idx   = w_cand;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin sharing of one serial transmitter among NUM_REQ requesters
// Optional send-to-Busy timeout with sticky error: define SERIAL_TX_ARB_TIMEOUT_EN.
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned DATA_W  = SERIAL_DATA_W,
   parameter  int unsigned TIMEOUT = SERIAL_TX_TIMEOUT,
   localparam int unsigned IDX_W   = idx_width(NUM_REQ)
)(
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]          o_req_ack,
   output logic [DATA_W-1:0]           o_tx_data,
   output logic                        o_tx_send,
   input  logic                        i_tx_busy,
   output logic [IDX_W-1:0]            o_grant_id,
   output logic                        o_idle,
   output logic                        o_tx_error
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("serial_tx_arbiter: parameter out of range");
   end

   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   arb_state_t           r_state;
   logic [NUM_REQ-1:0]   r_req_ack;
   logic [DATA_W-1:0]    r_tx_data;
   logic                 r_tx_send;
   logic [IDX_W-1:0]     r_grant_id;
   logic                 r_idle;
   logic [IDX_W-1:0]     w_win;
   logic                 w_found;

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     r_tmo_cnt;
   logic                 r_tx_error;
   logic                 w_tmo_hit;
   assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif

   // The last grant doubles as the round-robin pointer.
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_grant_id),
      .o_idx   (w_win),
      .o_found (w_found)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_req_ack  <= '0;
         r_tx_send  <= 1'b0;
         r_tx_data  <= '0;
         r_grant_id <= LAST_IDX;
         r_idle     <= 1'b1;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
         r_tmo_cnt  <= '0;
         r_tx_error <= 1'b0;
`endif
      end else begin
         r_req_ack <= '0;
         r_tx_send <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A frame still shifting out (e.g. after reset) blocks the grant.
               if (!i_tx_busy && w_found) begin
                  r_tx_data  <= i_req_data[int'(w_win)*DATA_W +: DATA_W];
                  r_grant_id <= w_win;
                  r_req_ack  <= ONE_HOT0 << w_win;
                  r_tx_send  <= 1'b1;
                  r_idle     <= 1'b0;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT_BUSY;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
            end
            ST_WAIT_BUSY: begin
               if (i_tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
               else if (w_tmo_hit) begin
                  r_tx_error <= 1'b1;
                  r_idle     <= 1'b1;
                  r_state    <= ST_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            ST_WAIT_DONE: begin
               if (!i_tx_busy) begin
                  r_idle  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_idle  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_ack  = r_req_ack;
   assign o_tx_data  = r_tx_data;
   assign o_tx_send  = r_tx_send;
   assign o_grant_id = r_grant_id;
   assign o_idle     = r_idle;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
   assign o_tx_error = r_tx_error;
`else
   assign o_tx_error = 1'b0;
`endif

endmodule
